// File: rtl/dti_rr_arbiter_pkg.sv
// Package for the dti round-robin arbiter.
//   arb_state_t : packet-lock FSM states (only used with DTI_RR_ARBITER_PKT_LOCK_EN)
//   rr_pick_t   : {found, idx} result of a round-robin scan
//   rr_pick()   : scans req starting at last+1 (mod n) and returns the first set bit.
// Vectors are sized for MAX_N requesters. Callers zero-extend their narrower request
// and index vectors, so N must not exceed MAX_N.
package dti_arb_pkg;

    localparam int MAX_N  = 32;
    localparam int MAX_IW = 6;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              found;
        logic [MAX_IW-1:0] idx;
    } rr_pick_t;

    // Explicit modulo so a non-power-of-two n wraps correctly. The scan starts
    // right after the last winner, which is what makes the priority rotate.
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]  req,
                                         input logic [MAX_IW-1:0] last,
                                         input int                n);
        rr_pick_t r;
        int       i;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            i = int'(last) + k;
            if (i >= n) i = i - n;
            if (k <= n && !r.found && req[i]) begin
                r.found = 1'b1;
                r.idx   = i[MAX_IW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dti_rr_arbiter_if.sv
// dti valid/ready channel.
//   data  : payload, W bits (producer -> consumer)
//   valid : payload present    (producer -> consumer)
//   ready : consumer accepts   (consumer -> producer)
// A beat transfers on a clock edge where valid && ready.
interface dti #(parameter int W = 16);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/dti_rr_arbiter_pick.sv
// rr_priority_pick: combinational round-robin selector that wraps
// dti_arb_pkg::rr_pick, so the scan can be checked on its own.
//   req   : request vector, one bit per requester
//   last  : index of the previous winner. The scan starts at last+1.
//   found : at least one request is set
//   idx   : winning index (only meaningful when found = 1)
module rr_priority_pick
    import dti_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [MAX_N-1:0]  req_ext;
    logic [MAX_IW-1:0] last_ext;
    rr_pick_t          pick;
    logic              unused_idx_hi;

    always_comb begin
        req_ext           = '0;
        req_ext[N-1:0]    = req;
        last_ext          = '0;
        last_ext[IW-1:0]  = last;
        pick              = rr_pick(req_ext, last_ext, N);
    end

    assign found         = pick.found;
    assign idx           = pick.idx[IW-1:0];
    assign unused_idx_hi = ^pick.idx[MAX_IW-1:IW];

endmodule

// File: rtl/dti_rr_arbiter.sv
// dti_rr_arbiter: round-robin arbiter that lets N dti producers share one dti
// output channel through a one-entry output register. Each output beat carries
// the index of the requester that won it.
//   clk  : clock, all state changes on posedge
//   rst  : asynchronous active-high reset
//   din  : N requester channels (consumer side), DIN bits each
//   dout : output channel (producer side), data = {grant_idx, din_data}
// Optional feature: define DTI_RR_ARBITER_PKT_LOCK_EN to enable packet lock.
// In that build, din data bit DIN-1 is end-of-transfer (eot), and once a beat
// with eot=0 transfers, the grant stays on that requester until it sends a beat
// with eot=1.
//
// Packet-lock FSM (only with DTI_RR_ARBITER_PKT_LOCK_EN):
//   state  | meaning
//   ARB    | free round-robin arbitration on every beat
//   LOCKED | grant pinned to lock_idx until a beat with eot=1 transfers
module dti_rr_arbiter
    import dti_arb_pkg::*;
#(
    parameter  int N   = 2,
    parameter  int DIN = 16,
    localparam int IW  = $clog2(N)
) (
    input  logic  clk,
    input  logic  rst,
    dti.consumer  din [N],
    dti.producer  dout
);

    logic [N-1:0]   req;
    logic [DIN-1:0] data_a [N];
    logic [N-1:0]   rdy;

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        assign req[gi]        = din[gi].valid;
        assign data_a[gi]     = din[gi].data;
        assign din[gi].ready  = rdy[gi];
    end

    logic [IW-1:0] last_grant;
    logic          pick_found;
    logic [IW-1:0] pick_idx;

    rr_priority_pick #(.N(N)) u_pick (
        .req   (req),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    logic [IW-1:0] grant;
    logic          grant_ok;
    logic          load_en;
    logic          xfer;

`ifdef DTI_RR_ARBITER_PKT_LOCK_EN
    arb_state_t    state;
    logic [IW-1:0] lock_idx;
    logic          eot;

    // While locked, nobody else gets ready, even when the locked requester is idle.
    always_comb begin
        grant    = pick_idx;
        grant_ok = pick_found;
        if (state == LOCKED) begin
            grant    = lock_idx;
            grant_ok = req[lock_idx];
        end
    end
    assign eot = data_a[grant][DIN-1];
`else
    always_comb begin
        grant    = pick_idx;
        grant_ok = pick_found;
    end
`endif

    assign load_en = !dout.valid || dout.ready;
    assign xfer    = load_en && grant_ok;

    // Gated by rst so no requester sees ready while the output register is held in reset.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = xfer && !rst && (grant == i[IW-1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout.valid <= 1'b0;
            dout.data  <= '0;
            last_grant <= IW'(N - 1);
`ifdef DTI_RR_ARBITER_PKT_LOCK_EN
            state      <= ARB;
            lock_idx   <= '0;
`endif
        end else if (load_en) begin
            dout.valid <= grant_ok;
            if (grant_ok) begin
                dout.data <= {grant, data_a[grant]};
`ifdef DTI_RR_ARBITER_PKT_LOCK_EN
                // Priority rotates only when a packet ends, so a packet counts as one turn.
                if (eot) begin
                    last_grant <= grant;
                    state      <= ARB;
                end else begin
                    lock_idx   <= grant;
                    state      <= LOCKED;
                end
`else
                last_grant <= grant;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dti_rr_arbiter.sv
module tb_dti_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dti #(.W(16)) din_if [4] ();
    dti #(.W(18)) dout_if ();

    dti_rr_arbiter #(.N(4), .DIN(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din_if),
        .dout (dout_if)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] rdy_v;
    assign rdy_v = {din_if[3].ready, din_if[2].ready, din_if[1].ready, din_if[0].ready};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic [3:0] v);
        din_if[0].valid = v[0];
        din_if[1].valid = v[1];
        din_if[2].valid = v[2];
        din_if[3].valid = v[3];
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected dout words for the default per-channel data 16'h8000+i (eot set).
    logic [17:0] beat_exp [4];

    initial begin
        beat_exp[0] = 18'h08000;
        beat_exp[1] = 18'h18001;
        beat_exp[2] = 18'h28002;
        beat_exp[3] = 18'h38003;

        rst = 1'b1;
        dout_if.ready = 1'b1;
        set_valid(4'b0000);
        din_if[0].data = 16'h8000;
        din_if[1].data = 16'h8001;
        din_if[2].data = 16'h8002;
        din_if[3].data = 16'h8003;
        #12;
        chk("reset_valid", 32'(dout_if.valid), 32'd0);
        chk("reset_data", 32'(dout_if.data), 32'd0);
        set_valid(4'b1111);
        #1;
        chk("reset_ready", 32'(rdy_v), 32'd0);

        // All requesters valid: grants rotate 0,1,2,3,0.
        tick();
        rst = 1'b0;
        #1;
        chk("rr_first_ready", 32'(rdy_v), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_beat%0d", k), 32'(dout_if.data), 32'(beat_exp[k % 4]));
            chk($sformatf("rr_valid%0d", k), 32'(dout_if.valid), 32'd1);
            chk($sformatf("rr_next_ready%0d", k), 32'(rdy_v), 32'(4'b0001 << ((k + 1) % 4)));
        end

        // Backpressure: the register holds and every ready stays low.
        dout_if.ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(rdy_v), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_data%0d", k), 32'(dout_if.data), 32'h08000);
            chk($sformatf("bp_valid%0d", k), 32'(dout_if.valid), 32'd1);
            chk($sformatf("bp_ready%0d", k), 32'(rdy_v), 32'd0);
        end
        dout_if.ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rdy_v), 32'b0010);
        tick();
        chk("bp_release_beat", 32'(dout_if.data), 32'h18001);

        // A single requester gets ready the first cycle after reset is released.
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(dout_if.valid), 32'd0);
        set_valid(4'b0100);
        din_if[2].data = 16'hA5A5;
        tick();
        rst = 1'b0;
        #1;
        chk("single_ready", 32'(rdy_v), 32'b0100);
        tick();
        chk("single_beat", 32'(dout_if.data), 32'h2A5A5);
        chk("single_valid", 32'(dout_if.valid), 32'd1);
        set_valid(4'b0000);
        tick();
        chk("idle_valid_drop", 32'(dout_if.valid), 32'd0);

        // Wrap: with last_grant=3, din[0] beats din[3].
        set_valid(4'b1000);
        din_if[3].data = 16'hB333;
        tick();
        chk("wrap_setup", 32'(dout_if.data), 32'h3B333);
        set_valid(4'b1001);
        #1;
        chk("wrap_ready", 32'(rdy_v), 32'b0001);
        tick();
        chk("wrap_beat0", 32'(dout_if.data), 32'h08000);
        chk("wrap_ready3", 32'(rdy_v), 32'b1000);
        tick();
        chk("wrap_beat3", 32'(dout_if.data), 32'h3B333);

        // Packet: din[1] sends 3 beats (eot on the last) while din[0] stays valid.
        set_valid(4'b0001);
        tick();
        chk("pkt_setup", 32'(dout_if.data), 32'h08000);
        din_if[1].data = 16'h0001;
        set_valid(4'b0011);
        tick();
        chk("pkt_b1", 32'(dout_if.data), 32'h10001);
        din_if[1].data = 16'h0002;
`ifdef DTI_RR_ARBITER_PKT_LOCK_EN
        #1;
        chk("pkt_lock_ready", 32'(rdy_v), 32'b0010);
        tick();
        chk("pkt_b2", 32'(dout_if.data), 32'h10002);
        din_if[1].data = 16'h8003;
        tick();
        chk("pkt_b3", 32'(dout_if.data), 32'h18003);
        set_valid(4'b0001);
        tick();
        chk("pkt_after", 32'(dout_if.data), 32'h08000);
`else
        tick();
        chk("alt_b2", 32'(dout_if.data), 32'h08000);
        tick();
        chk("alt_b3", 32'(dout_if.data), 32'h10002);
        tick();
        chk("alt_b4", 32'(dout_if.data), 32'h08000);
`endif

        // Reset while a beat is registered (and, with packet lock, a lock is held).
        din_if[1].data = 16'h0004;
        set_valid(4'b0011);
        tick();
        chk("rst_mid_beat", 32'(dout_if.data), 32'h10004);
        set_valid(4'b0001);
        #1;
`ifdef DTI_RR_ARBITER_PKT_LOCK_EN
        chk("lock_blocks_other", 32'(rdy_v), 32'b0000);
`else
        chk("no_lock_other", 32'(rdy_v), 32'b0001);
`endif
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(dout_if.valid), 32'd0);
        chk("rst_mid_data", 32'(dout_if.data), 32'd0);
        chk("rst_mid_ready", 32'(rdy_v), 32'd0);
        set_valid(4'b1111);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(rdy_v), 32'b0001);
        tick();
        chk("post_rst_beat", 32'(dout_if.data), 32'h08000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
